// File: rtl/wb_pkg.sv
// Shared widths and the buffered ALU result record for the write-back arbiter.
package wb_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned NUM_REGS   = 16;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned DEST_W     = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
  } entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer holding ALU results while the write port is taken.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned Depth = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  entry_t                     entry_i,
  input  logic                       pop_i,
  output entry_t                     head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Explicit wrap keeps non-power-of-two depths correct.
    if (do_push) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Single write port arbiter: memory loads first, then buffered ALU results, then ALU bypass.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W     = wb_pkg::DATA_W,
  parameter int unsigned NUM_REGS   = wb_pkg::NUM_REGS,
  parameter int unsigned FIFO_DEPTH = wb_pkg::FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid_i,
  output logic                alu_ready_o,
  input  logic [DATA_W-1:0]   alu_data_i,
  input  logic [3:0]          alu_dest_i,
  input  logic                mem_valid_i,
  input  logic [DATA_W-1:0]   mem_data_i,
  input  logic [3:0]          mem_dest_i,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic [NUM_REGS-1:0] wb_enable_o,
  output logic [1:0]          fifo_count_o,
  output logic [7:0]          conflict_cnt_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  entry_t              head;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CntW-1:0]     fifo_count;
  logic                alu_hs;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [NUM_REGS-1:0] wb_en_q, wb_en_d;
  logic [7:0]          conflict_q, conflict_d;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i] = (idx == 4'(i));
    return v;
  endfunction

  wb_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (fifo_push),
    .entry_i('{data: alu_data_i, dest: alu_dest_i}),
    .pop_i  (fifo_pop),
    .head_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // Readiness looks only at registered occupancy, never at a same-cycle pop.
  assign alu_ready_o = ~reset & ~fifo_full;
  assign alu_hs      = alu_valid_i & alu_ready_o;

  always_comb begin
    wb_en_d   = '0;
    wb_data_d = wb_data_q;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (mem_valid_i) begin
      wb_en_d   = onehot(mem_dest_i);
      wb_data_d = mem_data_i;
      fifo_push = alu_hs;
    end else if (!fifo_empty) begin
      wb_en_d   = onehot(head.dest);
      wb_data_d = head.data;
      fifo_pop  = 1'b1;
      fifo_push = alu_hs;
    end else if (alu_hs) begin
      wb_en_d   = onehot(alu_dest_i);
      wb_data_d = alu_data_i;
    end
  end

  always_comb begin
    conflict_d = conflict_q;
    if (mem_valid_i && (!fifo_empty || alu_valid_i) && conflict_q != 8'hFF) begin
      conflict_d = conflict_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en_q    <= '0;
      wb_data_q  <= '0;
      conflict_q <= '0;
    end else begin
      wb_en_q    <= wb_en_d;
      wb_data_q  <= wb_data_d;
      conflict_q <= conflict_d;
    end
  end

  assign wb_enable_o    = wb_en_q;
  assign wb_data_o      = wb_data_q;
  assign fifo_count_o   = 2'(fifo_count);
  assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Cycle-level scoreboard bench for wb_arbiter with directed and random stimulus.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid;
  logic [15:0] alu_data, mem_data, wb_data, wb_enable;
  logic [3:0]  alu_dest, mem_dest;
  logic [1:0]  fifo_count;
  logic [7:0]  conflict_cnt;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid_i   (alu_valid),
    .alu_ready_o   (alu_ready),
    .alu_data_i    (alu_data),
    .alu_dest_i    (alu_dest),
    .mem_valid_i   (mem_valid),
    .mem_data_i    (mem_data),
    .mem_dest_i    (mem_dest),
    .wb_data_o     (wb_data),
    .wb_enable_o   (wb_enable),
    .fifo_count_o  (fifo_count),
    .conflict_cnt_o(conflict_cnt)
  );

  typedef struct {
    logic [15:0] en;
    logic [15:0] data;
    logic [7:0]  cnt;
    logic [1:0]  fc;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dest;
  } ent_t;

  exp_t        sb[$];
  ent_t        mq[$];
  int          checks = 0;
  int          errors = 0;
  int          m_cnt  = 0;
  logic [15:0] m_last = 16'h0;

  // Drive one cycle, predict its outcome, then compare after the edge.
  task automatic cyc(input logic r, input logic mv, input logic [15:0] md, input logic [3:0] mdst,
                     input logic av, input logic [15:0] ad, input logic [3:0] adst);
    exp_t e;
    ent_t h;
    logic rdy, hs;
    reset = r; mem_valid = mv; mem_data = md; mem_dest = mdst;
    alu_valid = av; alu_data = ad; alu_dest = adst;
    #1;
    rdy = !r && (mq.size() < 2);
    checks++;
    assert (alu_ready === rdy) else begin
      errors++;
      $error("FAIL alu_ready got %b want %b", alu_ready, rdy);
    end
    hs = av && rdy;
    e.en = 16'h0;
    if (r) begin
      mq.delete();
      m_cnt  = 0;
      m_last = 16'h0;
    end else begin
      if (mv && (mq.size() > 0 || av) && m_cnt < 255) m_cnt++;
      if (mv) begin
        e.en = 16'h1 << mdst; m_last = md;
        if (hs) mq.push_back('{data: ad, dest: adst});
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        e.en = 16'h1 << h.dest; m_last = h.data;
        if (hs) mq.push_back('{data: ad, dest: adst});
      end else if (hs) begin
        e.en = 16'h1 << adst; m_last = ad;
      end
    end
    e.data = m_last;
    e.cnt  = 8'(m_cnt);
    e.fc   = 2'(mq.size());
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (wb_enable === e.en) else begin
      errors++;
      $error("FAIL wb_enable got %h want %h", wb_enable, e.en);
    end
    checks++;
    assert (wb_data === e.data) else begin
      errors++;
      $error("FAIL wb_data got %h want %h", wb_data, e.data);
    end
    checks++;
    assert (fifo_count === e.fc) else begin
      errors++;
      $error("FAIL fifo_count got %0d want %0d", fifo_count, e.fc);
    end
    checks++;
    assert (conflict_cnt === e.cnt) else begin
      errors++;
      $error("FAIL conflict_cnt got %0d want %0d", conflict_cnt, e.cnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    // Reset, with valids asserted to show they are ignored.
    cyc(1'b1, 1'b1, 16'h5555, 4'h1, 1'b1, 16'h6666, 4'h2);
    cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0);
    idle(2);

    // Bypass path.
    cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 16'h1234, 4'd5);
    idle(2);

    // Memory versus ALU in the same cycle.
    cyc(1'b0, 1'b1, 16'hBEEF, 4'd3, 1'b1, 16'h0001, 4'd7);
    idle(3);

    // Memory holds the port for four cycles; FIFO fills and backpressures.
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 16'hC000 + 16'(i), 4'(i), 1'b1, 16'hA000 + 16'(i), 4'(8 + i));
    idle(4);

    // Fill the FIFO then reset: buffered entries must vanish.
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b1, 16'hD000 + 16'(i), 4'(i), 1'b1, 16'hEE00 + 16'(i), 4'(12 + i));
    cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0);
    idle(4);

    // Random mix with FIFO wraparound and simultaneous push/pop.
    for (int i = 0; i < 60; i++)
      cyc(1'b0, 1'($urandom_range(0, 2) == 0), 16'($urandom), 4'($urandom),
          1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom));
    idle(3);

    // Saturation of the conflict counter.
    for (int i = 0; i < 300; i++)
      cyc(1'b0, 1'b1, 16'(i), 4'(i), 1'b1, 16'hF000 + 16'(i), 4'(i + 3));
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 16'h7700, 4'd2, 1'b1, 16'h8800, 4'd4);

    // Idle stretch: enable stays low and data holds.
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, width of write-back data and register width.
REQ-002 Parameter NUM_REGS, default 16, number of destination registers, which is also the wb_enable width.
REQ-003 Parameter FIFO_DEPTH, default 2, number of ALU results buffered while the write port is busy.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 alu_valid  input  1  ALU result offered this cycle.
REQ-007 alu_ready  output  1  arbiter accepts the ALU result this cycle.
REQ-008 alu_data  input  DATA_W  ALU result value.
REQ-009 alu_dest  input  4  ALU destination register index.
REQ-010 mem_valid  input  1  memory load result present; has no backpressure and is always accepted.
REQ-011 mem_data  input  DATA_W  load data.
REQ-012 mem_dest  input  4  load destination register index.
REQ-013 wb_data  output  DATA_W  write-back data; drives the register bank data bus.
REQ-014 wb_enable  output  NUM_REGS  one-hot write enable; drives the register bank per-register enables.
REQ-015 fifo_count  output  2  number of ALU entries currently buffered.
REQ-016 conflict_cnt  output  8  saturating count of arbitration conflicts.

Function
REQ-017 wb_data and wb_enable shall be registered, with 1-cycle latency from the cycle a write is selected.
REQ-018 wb_enable shall be all-zero in any cycle following a cycle with no selected write, and shall never have more than one bit set.
REQ-019 Priority each cycle: mem_valid first, then the FIFO head, then a direct ALU bypass.
REQ-020 When mem_valid=1, on the next edge: wb_enable = onehot(mem_dest) and wb_data = mem_data.
REQ-021 When mem_valid=0 and the FIFO is non-empty: the head is popped and driven to the output, in arrival order.
REQ-022 When mem_valid=0, the FIFO is empty, and an ALU handshake occurs: the ALU result bypasses the FIFO straight to the output and is not pushed.
REQ-023 Handshake: an ALU result is accepted on a cycle with alu_valid=1 and alu_ready=1; alu_data and alu_dest are sampled that cycle.
REQ-024 alu_ready = (fifo_count < FIFO_DEPTH) and not reset; it is combinational from registered state and shall not depend on alu_valid.
REQ-025 An accepted ALU result that is not bypassed shall be pushed at the FIFO tail.
REQ-026 Full FIFO: alu_ready=0 even if a pop occurs the same cycle; there is no push-on-full.
REQ-027 Simultaneous pop and push when the FIFO is not full: fifo_count is unchanged and order is preserved.
REQ-028 Pointers shall wrap modulo FIFO_DEPTH.
REQ-029 conflict_cnt shall increment by 1 on each cycle where mem_valid=1 and (FIFO non-empty or alu_valid=1).
REQ-030 conflict_cnt shall saturate at 255.
REQ-031 Write-after-write ordering between memory and ALU results to the same register is not resolved here; upstream guarantees it.

Reset
REQ-032 While reset=1, on each edge: wb_enable=0, wb_data=0, FIFO emptied, fifo_count=0, conflict_cnt=0.
REQ-033 Reset asserted mid-operation shall discard buffered entries, and no write for them shall ever appear.
REQ-034 mem_valid and alu_valid shall be ignored during reset cycles.
REQ-035 Normal operation shall begin on the first edge after reset deasserts.

Structure
REQ-036 Shared package wb_pkg shall hold DATA_W, NUM_REGS, FIFO_DEPTH, and the entry record type {data, dest}.
REQ-037 The FIFO shall be a sub-module named wb_fifo, with push/pop/full/empty/count and a registered storage array.
REQ-038 The one-hot decode and the arbitration logic shall reside in wb_arbiter.

Verification
REQ-039 Bypass: FIFO empty, alu_valid=1, data=0x1234, dest=5, mem idle -> next cycle wb_enable=0x0020 and wb_data=0x1234 for exactly one cycle.
REQ-040 Conflict: mem_valid=1 (0xBEEF, dest 3) with alu_valid=1 (0x0001, dest 7) -> cycle+1: 0x0008/0xBEEF; cycle+2: 0x0080/0x0001; conflict_cnt=1.
REQ-041 Full: mem_valid held 1 for 4 cycles with ALU offering every cycle -> alu_ready drops after 2 accepts; fifo_count=2; both entries later retire in order.
REQ-042 Saturation: 300 conflict cycles -> conflict_cnt=255 and remains 255.
REQ-043 Reset mid-operation: fifo_count=2, then reset for 1 cycle -> wb_enable=0; fifo_count=0; the buffered values never appear on wb_data.
REQ-044 Idle: no valids for 10 cycles -> wb_enable=0 throughout, and wb_data holds its last value.
